nest_checker: RTL and testbench
===============================

Name: nest_checker

Overview:
- Parametrised successor to the P1 begin/end block checker.
- Consumes an ASCII character stream one byte per valid cycle and tracks `begin`/`end` keyword nesting.
- Reports balance, current nesting depth and a sticky error.
- Sits after the character source in the P1 text-checking path; adds input qualification, configurable case sensitivity, bounded-depth overflow detection and a depth output.

Parameters:
- DEPTH_W, 8, width of the nesting-depth counter; maximum depth = 2^DEPTH_W - 1.
- CASE_SENS, 0, 0 = keywords match in any letter case; 1 = only lowercase `begin`/`end` match.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  `in` is sampled only when high.
- in  input  8  ASCII character.
- result  output  1  1 when the stream is balanced (depth==0) and no error.
- depth  output  DEPTH_W  current committed nesting depth.
- error  output  1  sticky underflow/overflow flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: depth=0, error=0, result=1, tokenizer state=IDLE.
- All outputs are registered. A keyword commit caused by the character sampled at edge N is visible after edge N.
- Delimiter is space (0x20) only. Every other byte, including punctuation and digits, is a word character.
- Case folding when CASE_SENS=0: A–Z are mapped to a–z before matching. Other bytes are unchanged. When CASE_SENS=1, no folding is done.
- Tokenizer states and transitions on a valid char c:
  - IDLE: 'b'->B1, 'e'->E1, space->IDLE, other->OTHER.
  - B1 'e'->B2; B2 'g'->B3; B3 'i'->B4; B4 'n'->B5.
  - E1 'n'->E2; E2 'd'->E3.
  - Any mismatching non-space char in B1..B5, E1..E3 ->OTHER.
  - Space in any state ->IDLE.
  - OTHER: non-space->OTHER, space->IDLE.
- Commit happens only when a space is sampled while in B5 (begin) or E3 (end):
  - begin: if depth == 2^DEPTH_W-1, set error and leave depth unchanged; else depth+1.
  - end: if depth == 0, set error and leave depth unchanged; else depth-1.
- A word longer than the keyword (`ende`, `beginx`) never commits. A prefix (`beg `) never commits.
- Repeated spaces have no effect. A keyword at end of stream without a trailing space is not counted.
- in_valid low: tokenizer state, depth and error all hold. `in` is ignored.
- Error is sticky until reset. While error=1, depth is frozen and no further commits occur; the tokenizer keeps running.
- result = (depth==0) && !error, registered alongside depth/error.
- Reset mid-word returns the tokenizer to IDLE, so the partial word is discarded. Reset asserted together with a valid space wins.

Decomposition:
- Shared package nest_pkg holds:
  - ASCII constants CH_SPACE, CH_B, CH_E, CH_G, CH_I, CH_N, CH_D (lowercase).
  - Tokenizer state enum tok_state_t (IDLE, B1..B5, E1..E3, OTHER).
- One natural sub-module, nest_char_fold: combinational case normaliser, parametrised by CASE_SENS, 8-bit in/out.
- Tokenizer FSM, depth counter and error logic live in nest_checker.

Test Plan:
- Stream "begin end " (valid every cycle) -> depth 0->1 after 1st space, ->0 after 2nd space; result 1,0,1; error 0.
- Stream "end begin " from reset -> error=1 after 1st space; result=0 and depth=0 thereafter; result stays 0 after "begin ".
- CASE_SENS=0, "BEgin " -> depth=1, result=0. CASE_SENS=1, same stream -> depth=0, result=1.
- "b BEgin ende end end  BEgin " with CASE_SENS=0:
  - depth after each committed word: begin->1, end->0, second end->error=1.
  - Final result=0, depth=0; "ende" does not commit.
- DEPTH_W=2, "begin " x4 -> depth 1,2,3; 4th sets error=1, depth stays 3, result=0.
- Gaps and reset:
  - "beg", then in_valid=0 for 3 cycles with in="x", then "in " -> depth=1.
  - Separate run: "begi", reset, "n " -> depth=0, result=1.

Source files
------------

// File: rtl/nest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nest_pkg
// Description : Shared ASCII constants and tokenizer state type for nest_checker
// Revision    : 1.0 - initial release
// ============================================================================
package nest_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_D     = 8'h64;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        B1    = 4'd1,
        B2    = 4'd2,
        B3    = 4'd3,
        B4    = 4'd4,
        B5    = 4'd5,
        E1    = 4'd6,
        E2    = 4'd7,
        E3    = 4'd8,
        OTHER = 4'd9
    } tok_state_t;

endpackage
`default_nettype wire

// File: rtl/nest_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : nest_checker_if
// Description : Character-in / status-out bundle for nest_checker
// Revision    : 1.0 - initial release
// ============================================================================
interface nest_checker_if #(
    parameter int DEPTH_W = 8
);
    logic               in_valid;
    logic [7:0]         in;
    logic               result;
    logic [DEPTH_W-1:0] depth;
    logic               error;

    modport master (output in_valid, output in, input result, input depth, input error);
    modport slave  (input in_valid, input in, output result, output depth, output error);
endinterface
`default_nettype wire

// File: rtl/nest_char_fold.sv
`default_nettype none
// ============================================================================
// Module      : nest_char_fold
// Description : Combinational A-Z to a-z folding, bypassed when CASE_SENS=1
// Revision    : 1.0 - initial release
// ============================================================================
module nest_char_fold #(
    parameter bit CASE_SENS = 1'b0
) (
    input  wire logic [7:0] i_ch,
    output logic      [7:0] o_ch
);

    generate
        if (CASE_SENS) begin : g_nofold
            assign o_ch = i_ch;
        end else begin : g_fold
            logic w_upper;
            assign w_upper = (i_ch >= 8'h41) && (i_ch <= 8'h5A);
            assign o_ch    = w_upper ? (i_ch | 8'h20) : i_ch;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nest_checker.sv
`default_nettype none
// ============================================================================
// Module      : nest_checker
// Description : begin/end keyword nesting tracker with bounded depth and sticky error
// Revision    : 1.0 - initial release
// ============================================================================
module nest_checker
    import nest_pkg::*;
#(
    parameter int DEPTH_W   = 8,
    parameter bit CASE_SENS = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    nest_checker_if.slave bus
);

    localparam logic [DEPTH_W-1:0] c_depth_max = '1;

    logic [7:0]         w_ch;
    logic               w_space;
    tok_state_t         r_state;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_error;
    logic               r_result;

    nest_char_fold #(.CASE_SENS(CASE_SENS)) u_fold (
        .i_ch (bus.in),
        .o_ch (w_ch)
    );

    assign w_space    = (w_ch == CH_SPACE);
    assign bus.depth  = r_depth;
    assign bus.error  = r_error;
    assign bus.result = r_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_depth  <= '0;
            r_error  <= 1'b0;
            r_result <= 1'b1;
        end else if (bus.in_valid) begin
            if (w_space) begin
                r_state <= IDLE;
                // Commits only on the delimiter, and never once the error is latched.
                if (!r_error && r_state == B5) begin
                    if (r_depth == c_depth_max) begin
                        r_error  <= 1'b1;
                        r_result <= 1'b0;
                    end else begin
                        r_depth  <= r_depth + 1'b1;
                        r_result <= 1'b0;
                    end
                end else if (!r_error && r_state == E3) begin
                    if (r_depth == '0) begin
                        r_error  <= 1'b1;
                        r_result <= 1'b0;
                    end else begin
                        r_depth  <= r_depth - 1'b1;
                        r_result <= (r_depth == {{(DEPTH_W-1){1'b0}}, 1'b1});
                    end
                end
            end else begin
                case (r_state)
                    IDLE:    r_state <= (w_ch == CH_B) ? B1 : (w_ch == CH_E) ? E1 : OTHER;
                    B1:      r_state <= (w_ch == CH_E) ? B2 : OTHER;
                    B2:      r_state <= (w_ch == CH_G) ? B3 : OTHER;
                    B3:      r_state <= (w_ch == CH_I) ? B4 : OTHER;
                    B4:      r_state <= (w_ch == CH_N) ? B5 : OTHER;
                    E1:      r_state <= (w_ch == CH_N) ? E2 : OTHER;
                    E2:      r_state <= (w_ch == CH_D) ? E3 : OTHER;
                    default: r_state <= OTHER;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nest_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nest_checker
// Description : Three nest_checker configurations driven in lockstep against a word-level model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nest_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nest_checker_if #(.DEPTH_W(8)) bus0 ();
    nest_checker_if #(.DEPTH_W(8)) bus1 ();
    nest_checker_if #(.DEPTH_W(2)) bus2 ();

    nest_checker #(.DEPTH_W(8), .CASE_SENS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    nest_checker #(.DEPTH_W(8), .CASE_SENS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    nest_checker #(.DEPTH_W(2), .CASE_SENS(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;

    // Reference: buffer the current word, judge it whole when a space arrives.
    byte unsigned word_q[$];
    int m_depth[3];
    bit m_err[3];
    int m_max[3] = '{255, 255, 3};
    bit m_cs[3]  = '{1'b0, 1'b1, 1'b0};

    string words[12] = '{"begin", "end", "BEgin", "END", "ende", "beg",
                         "b", "x1", "Begin", "beginx", "en", "End"};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_kw(input bit cs, input string kw);
        byte unsigned b;
        if (word_q.size() != kw.len()) return 1'b0;
        for (int i = 0; i < kw.len(); i++) begin
            b = word_q[i];
            if (!cs && b >= 8'h41 && b <= 8'h5A) b = b + 8'h20;
            if (b != kw[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_update(input bit v, input byte unsigned c, input bit r);
        if (r) begin
            word_q.delete();
            for (int k = 0; k < 3; k++) begin
                m_depth[k] = 0;
                m_err[k]   = 1'b0;
            end
        end else if (v) begin
            if (c == 8'h20) begin
                for (int k = 0; k < 3; k++) begin
                    if (!m_err[k]) begin
                        if (is_kw(m_cs[k], "begin")) begin
                            if (m_depth[k] == m_max[k]) m_err[k] = 1'b1;
                            else m_depth[k]++;
                        end else if (is_kw(m_cs[k], "end")) begin
                            if (m_depth[k] == 0) m_err[k] = 1'b1;
                            else m_depth[k]--;
                        end
                    end
                end
                word_q.delete();
            end else begin
                word_q.push_back(c);
            end
        end
    endtask

    task automatic check_one(input string name, input int k, input logic [31:0] d,
                             input logic e, input logic r);
        check({name, ".depth"},  d, m_depth[k]);
        check({name, ".error"},  {31'd0, e}, {31'd0, m_err[k]});
        check({name, ".result"}, {31'd0, r}, {31'd0, (m_depth[k] == 0) && !m_err[k]});
    endtask

    task automatic step(input bit v, input byte unsigned c, input bit r);
        reset         = r;
        bus0.in_valid = v; bus0.in = c;
        bus1.in_valid = v; bus1.in = c;
        bus2.in_valid = v; bus2.in = c;
        @(posedge clk);
        model_update(v, c, r);
        #1;
        check_one("nocase8", 0, {24'd0, bus0.depth}, bus0.error, bus0.result);
        check_one("case8",   1, {24'd0, bus1.depth}, bus1.error, bus1.result);
        check_one("nocase2", 2, {30'd0, bus2.depth}, bus2.error, bus2.result);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        bus0.in_valid = 1'b0; bus0.in = 8'h00;
        bus1.in_valid = 1'b0; bus1.in = 8'h00;
        bus2.in_valid = 1'b0; bus2.in = 8'h00;
        do_reset();
        do_reset();

        send_str("begin end ");
        do_reset();
        send_str("end begin ");
        do_reset();
        send_str("BEgin ");
        do_reset();
        send_str("b BEgin ende end end  BEgin ");
        do_reset();
        send_str("begin begin begin begin ");
        do_reset();
        send_str("beg");
        for (int i = 0; i < 3; i++) step(1'b0, "x", 1'b0);
        send_str("in ");
        do_reset();
        send_str("begi");
        do_reset();
        send_str("n ");
        send_str("begin");
        step(1'b1, 8'h20, 1'b1);

        for (int n = 0; n < 600; n++) begin
            string w;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 4) begin
                step($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h62, 1'b1);
            end else begin
                w = words[$urandom_range(0, 11)];
                for (int i = 0; i < w.len(); i++) begin
                    if ($urandom_range(0, 9) == 0) step(1'b0, 8'($urandom), 1'b0);
                    if ($urandom_range(0, 49) == 0) step(1'b1, 8'($urandom_range(33, 126)), 1'b0);
                    step(1'b1, w[i], 1'b0);
                end
                if ($urandom_range(0, 7) != 0) step(1'b1, 8'h20, 1'b0);
                if ($urandom_range(0, 5) == 0) step(1'b1, 8'h20, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
